// File: rtl/cla_pkg.sv
// Shared types and constants for the byte-serial CLA word sequencer.
package cla_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-bit counter is the narrowest useful index, even for tiny widths.
  function automatic int idx_width(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/FA_lookahead_8bit.sv
// 8-bit carry-lookahead adder: every carry is formed from generate/propagate
// terms and cin directly, without rippling through the previous carry.
module FA_lookahead_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;
  logic       acc;
  logic       term;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc = cin;
      for (int k = 0; k <= i; k++) acc = acc & p[k];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end

endmodule

// File: rtl/cla_word_sequencer.sv
// Multi-precision add/subtract: one 8-bit CLA time-shared across an NBYTES-wide
// operand, least-significant byte first, with valid/ready on both sides.
module cla_word_sequencer
  import cla_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output state_e       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; in_ready and out_valid depend on the state register only.

  localparam int IW = idx_width(NBYTES);

  state_e            state;
  state_e            state_nx;
  logic [W-1:0]      a_sh;
  logic [W-1:0]      b_sh;
  logic [W-1:0]      res;
  logic              carry;
  logic              ovf;
  logic [IW-1:0]     idx;
  logic [BYTE_W-1:0] cla_sum;
  logic              cla_cout;
  logic              last_byte;

  FA_lookahead_8bit u_cla (
    .a    (a_sh[BYTE_W-1:0]),
    .b    (b_sh[BYTE_W-1:0]),
    .cin  (carry),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  assign last_byte = (idx == IW'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_byte) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: b is inverted on capture and the +1 enters
  // as the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= op_a;
            b_sh  <= sub ? ~op_b : op_b;
            carry <= sub;
            ovf   <= 1'b0;
            idx   <= '0;
          end
        end
        RUN: begin
          a_sh  <= {{BYTE_W{1'b0}}, a_sh[W-1:BYTE_W]};
          b_sh  <= {{BYTE_W{1'b0}}, b_sh[W-1:BYTE_W]};
          res   <= {cla_sum, res[W-1:BYTE_W]};
          carry <= cla_cout;
          idx   <= idx + IW'(1);
          if (last_byte) begin
            ovf <= (a_sh[BYTE_W-1] == b_sh[BYTE_W-1]) &&
                   (cla_sum[BYTE_W-1] != a_sh[BYTE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = res;
  assign carry_out = carry;
  assign overflow  = ovf;
  assign fsm_state = state;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed and randomized checks of cla_word_sequencer (NBYTES=4) against an
// arithmetic reference model.
module tb_cla_word_sequencer;
  import cla_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         busy;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  state_e       fsm_state;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q[$];

  cla_word_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: {overflow, carry_out, result} from whole-word arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W:0] full;
    logic       ov;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      ov   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end
    return {ov, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  64'(in_ready),  64'd1);
    check({tag, ".busy"},      64'(busy),      64'd0);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".result"},    64'(result),    64'd0);
    check({tag, ".carry"},     64'(carry_out), 64'd0);
    check({tag, ".ovf"},       64'(overflow),  64'd0);
  endtask

  // Called at a negedge while idle; returns just after the acceptance edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
  endtask

  // Counts rising edges until out_valid is seen at a negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
  endtask

  task automatic check_result(input string tag, input logic [W+1:0] e);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"},    64'(result),    64'(e[W-1:0]));
    check({tag, ".carry"},     64'(carry_out), 64'(e[W]));
    check({tag, ".ovf"},       64'(overflow),  64'(e[W+1]));
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".in_ready_after"},  64'(in_ready),  64'd1);
    check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                          input logic exp_v);
    int lat;
    issue(a, b, s);
    wait_done(lat);
    check({tag, ".latency"}, 64'(lat), 64'(NB));
    check_result(tag, {exp_v, exp_c, exp_r});
    check({tag, ".model"}, 64'({overflow, carry_out, result}), 64'(model(a, b, s)));
    take_result(tag);
  endtask

  initial begin
    int            lat;
    int            issued;
    int            got;
    int            last_cyc;
    logic [W+1:0]  e;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          rs;
    logic [W-1:0]  specials[4];

    specials[0] = 32'h0000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Directed arithmetic cases
    directed("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    directed("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_7_5",    32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    directed("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: result held with out_ready low
    issue(32'h1234_0000, 32'h0000_ABCD, 1'b0);
    wait_done(lat);
    e = model(32'h1234_0000, 32'h0000_ABCD, 1'b0);
    check_result("bp_first", e);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_result("bp_hold", e);
      check("bp_hold.in_ready", 64'(in_ready), 64'd0);
      check("bp_hold.busy",     64'(busy),     64'd1);
    end
    take_result("bp");

    // in_valid pulsed during RUN is ignored
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    @(negedge clk);
    op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    check("ignore.latency", 64'(lat), 64'(NB - 1));
    check_result("ignore", model(32'h0F0F_0F0F, 32'h0101_0101, 1'b1));
    check("ignore.value", 64'(result), 64'h0E0E_0E0E);
    take_result("ignore");

    // Reset after two bytes of RUN
    issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrun_rst_release");
    directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Back-to-back randomized stream
    issued   = 0;
    got      = 0;
    last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 1000 * (NB + 2) + 100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream.spurious", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream.result", 64'(result),    64'(e[W-1:0]));
          check("stream.carry",  64'(carry_out), 64'(e[W]));
          check("stream.ovf",    64'(overflow),  64'(e[W+1]));
        end
        if (last_cyc >= 0) check("stream.interval", 64'(cyc - last_cyc), 64'(NB + 2));
        last_cyc = cyc;
        got++;
      end
      if (in_ready && issued < 1000) begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 7) == 0) ra = specials[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) == 0) rb = specials[$urandom_range(0, 3)];
        rs = 1'($urandom_range(0, 1));
        op_a = ra; op_b = rb; sub = rs; in_valid = 1'b1;
        exp_q.push_back(model(ra, rb, rs));
        issued++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
      end
      if (got == 1000) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream.count", 64'(got), 64'd1000);
    check("stream.queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
